// File: rtl/mem_store_unit.sv
// Store unit: narrows a register value onto a 32-bit little-endian write port with byte enables.
// Define STORE_SPLIT_EN to turn misaligned SH/SW into one or two aligned word writes.
module mem_store_unit (
    input  logic        clk,
    input  logic        rstn,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    input  logic [1:0]  st_size,
    output logic        mem_req,
    input  logic        mem_gnt,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    output logic        st_done,
    output logic        addr_err,
    output logic [31:0] err_addr
);

`ifdef STORE_SPLIT_EN
    typedef enum logic [1:0] {StIdle, StReqLo, StReqHi, StDone} state_e;
`else
    typedef enum logic [1:0] {StIdle, StReqLo, StDone} state_e;
`endif

    state_e      state_q, state_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic        addr_err_q, addr_err_d;
    logic [31:0] err_addr_q, err_addr_d;

    logic [1:0]  off;
    logic        misaligned;
    logic        st_err;
    logic [31:0] lane_wdata;
    logic [3:0]  lane_be;

`ifdef STORE_SPLIT_EN
    logic [3:0]  size_mask;
    logic [63:0] data64;
    logic [7:0]  be64;
    logic        need_hi_q, need_hi_d;
    logic [31:0] hi_addr_q, hi_addr_d;
    logic [31:0] hi_wdata_q, hi_wdata_d;
    logic [3:0]  hi_be_q, hi_be_d;
`endif

    assign off        = st_addr[1:0];
    assign misaligned = ((st_size == 2'b01) && off[0]) || ((st_size == 2'b10) && (off != 2'b00));

    // Lane placement for the first (or only) word write.
    always_comb begin
        lane_wdata = st_data;
        lane_be    = 4'b1111;
        unique case (st_size)
            2'b00: begin
                lane_wdata = {4{st_data[7:0]}};
                lane_be    = 4'b0001 << off;
            end
            2'b01: begin
                lane_wdata = {2{st_data[15:0]}};
                lane_be    = off[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                lane_wdata = st_data;
                lane_be    = 4'b1111;
            end
        endcase
`ifdef STORE_SPLIT_EN
        size_mask = (st_size == 2'b01) ? 4'b0011 : 4'b1111;
        data64    = {32'b0, st_data} << {off, 3'b000};
        be64      = {4'b0000, size_mask} << off;
        if (misaligned) begin
            lane_wdata = data64[31:0];
            lane_be    = be64[3:0];
        end
        st_err = (st_size == 2'b11);
`else
        st_err = (st_size == 2'b11) || misaligned;
`endif
    end

    always_comb begin
        state_d     = state_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        addr_err_d  = 1'b0;
        err_addr_d  = err_addr_q;
`ifdef STORE_SPLIT_EN
        need_hi_d   = need_hi_q;
        hi_addr_d   = hi_addr_q;
        hi_wdata_d  = hi_wdata_q;
        hi_be_d     = hi_be_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (st_valid) begin
                    if (st_err) begin
                        addr_err_d = 1'b1;
                        err_addr_d = st_addr;
                    end else begin
                        state_d     = StReqLo;
                        mem_addr_d  = {st_addr[31:2], 2'b00};
                        mem_wdata_d = lane_wdata;
                        mem_be_d    = lane_be;
`ifdef STORE_SPLIT_EN
                        need_hi_d   = misaligned && (be64[7:4] != 4'b0000);
                        hi_addr_d   = {st_addr[31:2], 2'b00} + 32'd4;
                        hi_wdata_d  = data64[63:32];
                        hi_be_d     = be64[7:4];
`endif
                    end
                end
            end
            StReqLo: begin
                if (mem_gnt) begin
`ifdef STORE_SPLIT_EN
                    if (need_hi_q) begin
                        state_d     = StReqHi;
                        mem_addr_d  = hi_addr_q;
                        mem_wdata_d = hi_wdata_q;
                        mem_be_d    = hi_be_q;
                    end else begin
                        state_d = StDone;
                    end
`else
                    state_d = StDone;
`endif
                end
            end
`ifdef STORE_SPLIT_EN
            StReqHi: begin
                if (mem_gnt) begin
                    state_d = StDone;
                end
            end
`endif
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= StIdle;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            mem_be_q    <= 4'h0;
            addr_err_q  <= 1'b0;
            err_addr_q  <= 32'h0;
`ifdef STORE_SPLIT_EN
            need_hi_q   <= 1'b0;
            hi_addr_q   <= 32'h0;
            hi_wdata_q  <= 32'h0;
            hi_be_q     <= 4'h0;
`endif
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            addr_err_q  <= addr_err_d;
            err_addr_q  <= err_addr_d;
`ifdef STORE_SPLIT_EN
            need_hi_q   <= need_hi_d;
            hi_addr_q   <= hi_addr_d;
            hi_wdata_q  <= hi_wdata_d;
            hi_be_q     <= hi_be_d;
`endif
        end
    end

    assign st_ready  = (state_q == StIdle);
`ifdef STORE_SPLIT_EN
    assign mem_req   = (state_q == StReqLo) || (state_q == StReqHi);
`else
    assign mem_req   = (state_q == StReqLo);
`endif
    assign st_done   = (state_q == StDone);
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;
    assign addr_err  = addr_err_q;
    assign err_addr  = err_addr_q;

endmodule

// File: tb/tb_mem_store_unit.sv
// Self-checking bench for mem_store_unit: directed cases plus random stores against a byte-level model.
module tb_mem_store_unit;

    logic        clk = 1'b0;
    logic        rstn;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [1:0]  st_size;
    logic        mem_req;
    logic        mem_gnt;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        st_done;
    logic        addr_err;
    logic [31:0] err_addr;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] last_err = 32'h0;

    always #5 clk = ~clk;

    mem_store_unit dut (
        .clk       (clk),
        .rstn      (rstn),
        .st_valid  (st_valid),
        .st_ready  (st_ready),
        .st_addr   (st_addr),
        .st_data   (st_data),
        .st_size   (st_size),
        .mem_req   (mem_req),
        .mem_gnt   (mem_gnt),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .st_done   (st_done),
        .addr_err  (addr_err),
        .err_addr  (err_addr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] be_mask(input logic [3:0] be);
        logic [31:0] m;
        m = 32'h0;
        for (int i = 0; i < 4; i++) if (be[i]) m[8*i +: 8] = 8'hff;
        return m;
    endfunction

    // Byte-by-byte placement: each byte of the store lands at addr+i; group by word.
    task automatic model(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                         output bit err, output int nb,
                         output logic [31:0] a0, output logic [31:0] d0, output logic [3:0] b0,
                         output logic [31:0] a1, output logic [31:0] d1, output logic [3:0] b1);
        int          nbytes;
        logic [31:0] ba;
        bit          misal;
        nbytes = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
        misal  = (s == 2'd1 && a[0]) || (s == 2'd2 && a[1:0] != 2'd0);
`ifdef STORE_SPLIT_EN
        err = (s == 2'd3);
`else
        err = (s == 2'd3) || misal;
`endif
        a0 = {a[31:2], 2'b00};
        a1 = a0 + 32'd4;
        d0 = 32'h0; d1 = 32'h0; b0 = 4'h0; b1 = 4'h0; nb = 1;
        for (int i = 0; i < nbytes; i++) begin
            ba = a + i;
            if ({ba[31:2], 2'b00} == a0) begin
                b0[ba[1:0]] = 1'b1;
                d0[8*ba[1:0] +: 8] = d[8*i +: 8];
            end else begin
                nb = 2;
                b1[ba[1:0]] = 1'b1;
                d1[8*ba[1:0] +: 8] = d[8*i +: 8];
            end
        end
`ifndef STORE_SPLIT_EN
        // Single-word writes replicate the narrow value across all lanes.
        if (s == 2'd0) d0 = {24'h0, d[7:0]} * 32'h01010101;
        else if (s == 2'd1) d0 = {16'h0, d[15:0]} * 32'h00010001;
        else d0 = d;
`endif
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            st_valid = 1'b0;
            mem_gnt  = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            mem_gnt = 1'b0;
            check("idle_req", mem_req, 0);
            check("idle_err", addr_err, 0);
            check("idle_err_addr", err_addr, last_err);
            check("idle_ready", st_ready, 1);
        end
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                            input int dly);
        bit          err;
        int          nb;
        logic [31:0] a0, d0, a1, d1, ea, ed;
        logic [3:0]  b0, b1, eb;
        model(a, d, s, err, nb, a0, d0, b0, a1, d1, b1);
        st_valid = 1'b1; st_addr = a; st_data = d; st_size = s;
        check("accept_ready", st_ready, 1);
        @(posedge clk); #1;
        st_valid = 1'b0; st_addr = $urandom; st_data = $urandom; st_size = 2'($urandom);
        if (err) begin
            last_err = a;
            check("err_pulse", addr_err, 1);
            check("err_addr", err_addr, a);
            check("err_no_req", mem_req, 0);
            check("err_ready", st_ready, 1);
            check("err_no_done", st_done, 0);
            return;
        end
        check("no_err", addr_err, 0);
        for (int k = 0; k < nb; k++) begin
            ea = (k == 0) ? a0 : a1;
            ed = (k == 0) ? d0 : d1;
            eb = (k == 0) ? b0 : b1;
            for (int c = 0; c <= dly; c++) begin
                check("req", mem_req, 1);
                check("addr", mem_addr, ea);
                check("be", mem_be, eb);
`ifdef STORE_SPLIT_EN
                check("wdata", mem_wdata & be_mask(eb), ed & be_mask(eb));
`else
                check("wdata", mem_wdata, ed);
`endif
                check("busy_done", st_done, 0);
                check("busy_ready", st_ready, 0);
                mem_gnt  = (c == dly);
                st_valid = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
                mem_gnt = 1'b0;
            end
        end
        st_valid = 1'b0;
        mem_gnt  = 1'($urandom_range(0, 1));
        check("done", st_done, 1);
        check("done_req", mem_req, 0);
        @(posedge clk); #1;
        mem_gnt = 1'b0;
        check("done_once", st_done, 0);
        check("post_ready", st_ready, 1);
        check("post_req", mem_req, 0);
    endtask

    initial begin
        rstn = 1'b0; st_valid = 1'b0; st_addr = 32'h0; st_data = 32'h0; st_size = 2'b00;
        mem_gnt = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req", mem_req, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_be", mem_be, 0);
        check("rst_done", st_done, 0);
        check("rst_err", addr_err, 0);
        check("rst_err_addr", err_addr, 0);
        check("rst_ready", st_ready, 1);
        rstn = 1'b1;
        idle(1);

        do_store(32'h0000_1003, 32'hAABB_CCDD, 2'b00, 0);
        idle(1);
        do_store(32'h0000_2002, 32'h1234_5678, 2'b01, 3);
        idle(1);
        do_store(32'h0000_3001, 32'hCAFE_F00D, 2'b10, 1);
        do_store(32'h0000_3004, 32'hCAFE_F00D, 2'b10, 0);
        idle(1);
        do_store(32'h0000_0000, 32'h5555_AAAA, 2'b11, 0);
        idle(2);
        do_store(32'h0000_4003, 32'h1122_3344, 2'b10, 1);
        idle(1);
        do_store(32'hFFFF_FFFE, 32'h8765_4321, 2'b10, 0);
        idle(1);

        // Reset while a request waits for its grant.
        st_valid = 1'b1; st_addr = 32'h0000_5000; st_data = 32'hDEAD_BEEF; st_size = 2'b10;
        @(posedge clk); #1;
        st_valid = 1'b0;
        check("mid_req", mem_req, 1);
        rstn = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_req", mem_req, 0);
        check("mid_rst_done", st_done, 0);
        check("mid_rst_be", mem_be, 0);
        check("mid_rst_addr", mem_addr, 0);
        check("mid_rst_err_addr", err_addr, 0);
        rstn = 1'b1;
        last_err = 32'h0;
        @(posedge clk); #1;
        check("mid_ready", st_ready, 1);
        check("mid_no_done", st_done, 0);

        for (int n = 0; n < 200; n++) begin
            logic [31:0] ra;
            ra = $urandom;
            if ($urandom_range(0, 7) == 0) ra = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            do_store(ra, $urandom, 2'($urandom_range(0, 3)), $urandom_range(0, 3));
            idle($urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
